// File: rtl/loader_pkg.sv
// Shared state encoding and data width for the instruction loader.
package loader_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      RUN   = 2'd3
   } ld_state_t;

endpackage

// File: rtl/ins_fifo.sv
// Small synchronous FIFO; pointers carry a wrap bit to tell full from empty.
module ins_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         do_push;
   logic         do_pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   assign do_pop  = pop && !empty;
   // a pop frees the slot this edge, so push on full is still safe
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + ONE;
         if (do_pop)  rptr <= rptr + ONE;
      end
   end

endmodule

// File: rtl/ins_loader.sv
// Host-to-imem instruction loader; holds the core in reset until loaded.
// Optional XOR checksum output enabled by LOADER_CHECKSUM_EN.
module ins_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOAD_REQ,
   input  logic              G_VALID,
   input  logic [DATA_W-1:0] G_DATA,
   input  logic              G_LAST,
   output logic              G_READY,
   output logic              WE,
   output logic [DATA_W-1:0] W_Ins,
   output logic [ADDR_W-1:0] W_Addr,
   output logic              CPU_RST,
   output logic              BUSY,
   output logic [ADDR_W:0]   WCOUNT,
`ifdef LOADER_CHECKSUM_EN
   output logic [DATA_W-1:0] CHKSUM,
`endif
   output logic              OVF
);

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_t       state;
   ld_state_t       nstate;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic            start;
   logic            wr;
   logic [DATA_W:0] q;
   logic            unused_last;

   assign push  = G_VALID && G_READY;
   assign pop   = !empty && BUSY;
   assign start = LOAD_REQ && (state == IDLE || state == RUN);
   // words past capacity are popped but never written
   assign wr    = pop && (WCOUNT != CAP);
   assign unused_last = q[DATA_W];

   ins_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .wdata ({G_LAST, G_DATA}),
      .pop   (pop),
      .rdata (q),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (LOAD_REQ) nstate = LOAD;
         LOAD:    if (push && G_LAST) nstate = DRAIN;
         DRAIN:   if (empty) nstate = RUN;
         RUN:     if (LOAD_REQ) nstate = LOAD;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      G_READY = 1'b0;
      BUSY    = 1'b0;
      CPU_RST = 1'b1;
      unique case (state)
         LOAD: begin
            G_READY = !full;
            BUSY    = 1'b1;
         end
         DRAIN:   BUSY    = 1'b1;
         RUN:     CPU_RST = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         WE     <= 1'b0;
         W_Ins  <= '0;
         W_Addr <= '0;
         WCOUNT <= '0;
         OVF    <= 1'b0;
      end else begin
         WE <= wr;
         if (start) begin
            WCOUNT <= '0;
            OVF    <= 1'b0;
         end else if (wr) begin
            W_Ins  <= q[DATA_W-1:0];
            W_Addr <= WCOUNT[ADDR_W-1:0];
            WCOUNT <= WCOUNT + ONE;
         end else if (pop) begin
            OVF <= 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)        CHKSUM <= '0;
      else if (start) CHKSUM <= '0;
      else if (wr)    CHKSUM <= CHKSUM ^ q[DATA_W-1:0];
   end
`endif

endmodule

// File: tb/tb_ins_loader.sv
// Randomized bench for ins_loader: host words vs. a word-list write model.
module tb_ins_loader;

   localparam int AW  = 3;
   localparam int CAP = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_req;
   logic          g_valid;
   logic [31:0]   g_data;
   logic          g_last;
   logic          g_ready;
   logic          we;
   logic [31:0]   w_ins;
   logic [AW-1:0] w_addr;
   logic          cpu_rst;
   logic          busy;
   logic [AW:0]   wcount;
   logic          ovf;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   chksum;
`endif

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          run_cyc = 0;
   logic [31:0] prog [$];
   int          wa_q [$];
   logic [31:0] wd_q [$];
   int          wc_q [$];

   ins_loader #(
      .ADDR_W     (AW),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .LOAD_REQ (load_req),
      .G_VALID  (g_valid),
      .G_DATA   (g_data),
      .G_LAST   (g_last),
      .G_READY  (g_ready),
      .WE       (we),
      .W_Ins    (w_ins),
      .W_Addr   (w_addr),
      .CPU_RST  (cpu_rst),
      .BUSY     (busy),
      .WCOUNT   (wcount),
`ifdef LOADER_CHECKSUM_EN
      .CHKSUM   (chksum),
`endif
      .OVF      (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory-side observer: every written word with its cycle stamp
   always @(negedge clk) begin
      if (rst === 1'b0 && we === 1'b1) begin
         wa_q.push_back(int'(w_addr));
         wd_q.push_back(w_ins);
         wc_q.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int exp_cnt(input int n);
      return (n < CAP) ? n : CAP;
   endfunction

   function automatic logic [31:0] exp_xor(input int n);
      logic [31:0] x = '0;
      for (int i = 0; i < exp_cnt(n); i++) x ^= prog[i];
      return x;
   endfunction

   task automatic make_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom());
   endtask

   task automatic start_load();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
   endtask

   task automatic send(input int from, input int to, input bit last,
                       input bit stall, output int waits);
      int k;
      waits = 0;
      for (int i = from; i < to; i++) begin
         if (stall) begin
            g_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         g_valid = 1'b1;
         g_data  = prog[i];
         g_last  = last && (i == to - 1);
         k = 0;
         while (g_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%0d g_ready=%b required 1",
                     i, g_ready);
            g_valid = 1'b0;
            return;
         end
         waits += k;
         @(negedge clk);
      end
      g_valid = 1'b0;
      g_last  = 1'b0;
   endtask

   task automatic wait_run();
      int k = 0;
      while (cpu_rst !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      run_cyc = cyc;
      checks++;
      if (cpu_rst !== 1'b0) begin
         errors++;
         $display("FAIL run_timeout cpu_rst=%b required 0", cpu_rst);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_req = 1'b0;
      g_valid = 1'b0;
      g_data = '0;
      g_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({g_ready, we, cpu_rst, busy, ovf} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_ctl rdy/we/crst/busy/ovf=%b required 00100",
                  {g_ready, we, cpu_rst, busy, ovf});
      end
      checks++;
      if (w_ins !== 32'h0 || int'(w_addr) !== 0 || int'(wcount) !== 0) begin
         errors++;
         $display("FAIL reset_data ins=%h addr=%0d cnt=%0d required 0/0/0",
                  w_ins, w_addr, wcount);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (chksum !== 32'h0) begin
         errors++;
         $display("FAIL reset_chksum got=%h required 0", chksum);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int w;
      prog.delete();
      prog.push_back(32'h20080005);
      prog.push_back(32'h20090003);
      prog.push_back(32'h01095020);
      start_load();
      checks++;
      if ({g_ready, busy, cpu_rst} !== 3'b111) begin
         errors++;
         $display("FAIL basic_enter rdy/busy/crst=%b required 111",
                  {g_ready, busy, cpu_rst});
      end
      send(0, 3, 1'b1, 1'b0, w);
      wait_run();
      checks++;
      if (wa_q.size() != 3) begin
         errors++;
         $display("FAIL basic_count got=%0d required 3", wa_q.size());
      end
      for (int i = 0; i < wa_q.size() && i < 3; i++) begin
         checks++;
         if (wa_q[i] != i || wd_q[i] !== prog[i] || wc_q[i] != wc_q[0] + i) begin
            errors++;
            $display("FAIL basic_w%0d addr=%0d data=%h cyc=%0d required %0d/%h/%0d",
                     i, wa_q[i], wd_q[i], wc_q[i], i, prog[i], wc_q[0] + i);
         end
      end
      checks++;
      if (int'(wcount) != 3 || ovf !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_final cnt=%0d ovf=%b busy=%b required 3/0/0",
                  wcount, ovf, busy);
      end
      if (wc_q.size() == 3) begin
         checks++;
         if (run_cyc != wc_q[2] + 1) begin
            errors++;
            $display("FAIL basic_release cyc=%0d required %0d",
                     run_cyc, wc_q[2] + 1);
         end
      end
   endtask

   task automatic test_stream();
      int w;
      make_prog(CAP);
      start_load();
      send(0, CAP, 1'b1, 1'b0, w);
      checks++;
      if (w != 0) begin
         errors++;
         $display("FAIL stream_stalls got=%0d required 0", w);
      end
      wait_run();
      checks++;
      if (wa_q.size() != CAP) begin
         errors++;
         $display("FAIL stream_count got=%0d required %0d", wa_q.size(), CAP);
      end
      for (int i = 0; i < wa_q.size() && i < CAP; i++) begin
         checks++;
         if (wa_q[i] != i || wd_q[i] !== prog[i]) begin
            errors++;
            $display("FAIL stream_w%0d addr=%0d data=%h required %0d/%h",
                     i, wa_q[i], wd_q[i], i, prog[i]);
         end
      end
      checks++;
      if (int'(wcount) != CAP || ovf !== 1'b0) begin
         errors++;
         $display("FAIL stream_full cnt=%0d ovf=%b required %0d/0",
                  wcount, ovf, CAP);
      end
   endtask

   task automatic test_overflow();
      int w;
      make_prog(CAP + 2);
      start_load();
      send(0, CAP + 2, 1'b1, 1'b1, w);
      wait_run();
      checks++;
      if (wa_q.size() != CAP || int'(wcount) != CAP || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_result writes=%0d cnt=%0d ovf=%b required %0d/%0d/1",
                  wa_q.size(), wcount, ovf, CAP, CAP);
      end
      if (wa_q.size() == CAP) begin
         checks++;
         if (wa_q[CAP-1] != CAP - 1 || wd_q[CAP-1] !== prog[CAP-1]) begin
            errors++;
            $display("FAIL ovf_lastword addr=%0d data=%h required %0d/%h",
                     wa_q[CAP-1], wd_q[CAP-1], CAP - 1, prog[CAP-1]);
         end
      end
   endtask

   task automatic test_reload();
      int w;
      make_prog(4);
      start_load();
      checks++;
      if (cpu_rst !== 1'b1 || int'(wcount) != 0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reload_clear crst=%b cnt=%0d ovf=%b required 1/0/0",
                  cpu_rst, wcount, ovf);
      end
      send(0, 2, 1'b0, 1'b0, w);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      send(2, 4, 1'b1, 1'b0, w);
      wait_run();
      checks++;
      if (int'(wcount) != 4 || wa_q.size() != 4) begin
         errors++;
         $display("FAIL reload_ignore cnt=%0d writes=%0d required 4/4",
                  wcount, wa_q.size());
      end
      for (int i = 0; i < wa_q.size() && i < 4; i++) begin
         checks++;
         if (wa_q[i] != i || wd_q[i] !== prog[i]) begin
            errors++;
            $display("FAIL reload_w%0d addr=%0d data=%h required %0d/%h",
                     i, wa_q[i], wd_q[i], i, prog[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int w;
      make_prog(4);
      start_load();
      send(0, 2, 1'b0, 1'b0, w);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({g_ready, we, cpu_rst, busy} !== 4'b0010 || int'(wcount) != 0 ||
          int'(w_addr) != 0 || w_ins !== 32'h0) begin
         errors++;
         $display("FAIL midrst_async rdy/we/crst/busy=%b cnt=%0d addr=%0d ins=%h required 0010/0/0/0",
                  {g_ready, we, cpu_rst, busy}, wcount, w_addr, w_ins);
      end
      @(negedge clk);
      rst = 1'b0;
      make_prog(3);
      start_load();
      send(0, 3, 1'b1, 1'b0, w);
      wait_run();
      checks++;
      if (wa_q.size() != 3) begin
         errors++;
         $display("FAIL midrst_count got=%0d required 3", wa_q.size());
      end
      for (int i = 0; i < wa_q.size() && i < 3; i++) begin
         checks++;
         if (wa_q[i] != i || wd_q[i] !== prog[i]) begin
            errors++;
            $display("FAIL midrst_w%0d addr=%0d data=%h required %0d/%h",
                     i, wa_q[i], wd_q[i], i, prog[i]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      int w;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, CAP + 4);
         make_prog(n);
         start_load();
         send(0, n, 1'b1, 1'b1, w);
         wait_run();
         checks++;
         if (wa_q.size() != exp_cnt(n) || int'(wcount) != exp_cnt(n) ||
             ovf !== (n > CAP)) begin
            errors++;
            $display("FAIL rand%0d_summary n=%0d writes=%0d cnt=%0d ovf=%b required %0d/%0d/%b",
                     it, n, wa_q.size(), wcount, ovf, exp_cnt(n), exp_cnt(n),
                     n > CAP);
         end
         for (int i = 0; i < wa_q.size() && i < exp_cnt(n); i++) begin
            checks++;
            if (wa_q[i] != i || wd_q[i] !== prog[i]) begin
               errors++;
               $display("FAIL rand%0d_w%0d addr=%0d data=%h required %0d/%h",
                        it, i, wa_q[i], wd_q[i], i, prog[i]);
            end
         end
`ifdef LOADER_CHECKSUM_EN
         checks++;
         if (chksum !== exp_xor(n)) begin
            errors++;
            $display("FAIL rand%0d_chksum got=%h required %h",
                     it, chksum, exp_xor(n));
         end
`endif
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int w;
      prog.delete();
      prog.push_back(32'h0000FFFF);
      prog.push_back(32'hFFFF0000);
      start_load();
      send(0, 2, 1'b1, 1'b0, w);
      wait_run();
      checks++;
      if (chksum !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL chksum_pair got=%h required ffffffff", chksum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stream();
      test_overflow();
      test_reload();
      test_mid_reset();
      test_random();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ins_loader.md
# ins_loader

Host-side instruction loader that sits directly upstream of the single-cycle MIPS environment block. It accepts 32-bit instruction words from a GPIO host over a valid/ready handshake and buffers them in a small FIFO. It then drives the environment's write-enable, instruction and address inputs one word per cycle. The core is held in reset until the program is fully written, then released to run.

## Interface
Parameters:
- ADDR_W, 6: instruction-memory address width; capacity 2^ADDR_W words.
- FIFO_DEPTH, 4: buffer depth in words; power of two, at least 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- LOAD_REQ  in  1  start a new load. Sampled in IDLE and RUN only.
- G_VALID  in  1  host word valid.
- G_DATA  in  32  host instruction word.
- G_LAST  in  1  qualifies G_DATA as the final word of the program.
- G_READY  out  1  loader can accept a word.
- WE  out  1  instruction-memory write strobe (registered).
- W_Ins  out  32  word being written (registered).
- W_Addr  out  ADDR_W  write address (registered).
- CPU_RST  out  1  reset to the core; high except in RUN.
- BUSY  out  1  high in LOAD and DRAIN.
- WCOUNT  out  ADDR_W+1  number of words written since the last LOAD_REQ.
- OVF  out  1  sticky capacity overflow.
- CHKSUM  out  32  present only with LOADER_CHECKSUM_EN.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: accepting host words.
  - DRAIN: last word accepted; FIFO emptying.
  - RUN: core released.
- Transitions:
  - IDLE→LOAD on LOAD_REQ.
  - LOAD→DRAIN on the transfer that has G_LAST=1.
  - DRAIN→RUN when the FIFO is empty and no write is pending.
  - RUN→LOAD on LOAD_REQ.
- Entering LOAD clears WCOUNT, OVF and CHKSUM; the next write address is 0.
- Transfer rule: a word transfers when G_VALID && G_READY.
  - G_READY = (state==LOAD) && FIFO not full.
  - G_DATA and G_LAST must stay stable while G_VALID is high and G_READY is low.
- Pop: one word per cycle whenever the FIFO is non-empty, in LOAD or DRAIN. The popped word is registered onto W_Ins and W_Addr, with WE=1 for exactly one cycle.
  - W_Addr = WCOUNT[ADDR_W-1:0] at the pop.
  - WCOUNT increments with each WE.
- Overflow: a pop when WCOUNT == 2^ADDR_W is discarded.
  - WE stays 0 and OVF is set; OVF holds until the next LOAD entry.
  - Draining continues normally.
- A simultaneous push and pop on a full FIFO is legal. G_READY still reads low while the FIFO is full.
- LOAD_REQ is ignored in LOAD and DRAIN.
- RST mid-load:
  - State returns to IDLE and the FIFO is flushed.
  - All outputs return to their reset values immediately (asynchronously).

## Timing
- Reset values:
  - G_READY=0, WE=0, W_Ins=0, W_Addr=0, CPU_RST=1, BUSY=0, WCOUNT=0, OVF=0, CHKSUM=0.
- State change takes effect at the edge after the triggering condition. G_READY rises the cycle after LOAD_REQ is sampled in IDLE.
- Latency with an empty FIFO:
  - Word accepted at edge k.
  - Popped at edge k+1.
  - WE high in the cycle after edge k+1, sampled by memory at edge k+2.
- Throughput: one word per cycle sustained.
- CPU_RST falls at the edge after the final WE cycle, coincident with the entry to RUN.
- Zero-length programs are not supported. The first word carrying G_LAST ends the program.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The CHKSUM port exists.
  - CHKSUM = XOR of all words written with WE=1 since LOAD entry, updated in the same cycle that WE is asserted.
  - Discarded overflow words are excluded.
- Not defined: the CHKSUM port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package loader_pkg holds:
  - The state enumeration (IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, RUN=2'd3).
  - DATA_W=32.
- Sub-module ins_fifo:
  - Synchronous FIFO parameterized by DATA_W+1 (data plus last flag) and FIFO_DEPTH.
  - Provides push, pop, full, empty.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- The top level holds the state machine, output registers, counters and the optional checksum.

## Test plan
- Reset then LOAD_REQ; push 3 words 0x20080005, 0x20090003, 0x01095020 (last) back-to-back → WE pulses at addresses 0,1,2 on consecutive cycles, WCOUNT=3, then CPU_RST falls.
- Hold WE sampling and push 8 words with the host never stalling; FIFO_DEPTH=4 → G_READY never asserted while full, all 8 words arrive in order at addresses 0–7, no loss.
- ADDR_W=2, push 6 words → addresses 0–3 written, OVF=1, WCOUNT=4, RUN still reached.
- Assert RST mid-LOAD after 2 words → all outputs at reset values at once; a new LOAD_REQ restarts at address 0.
- In RUN, assert LOAD_REQ → CPU_RST=1, WCOUNT=0, OVF=0; LOAD_REQ pulsed during LOAD is ignored.
- With LOADER_CHECKSUM_EN: push 0x0000FFFF, 0xFFFF0000 (last) → CHKSUM=0xFFFFFFFF.
